// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the Wishbone classic master bridge
// Bridge FSM states and the internal response code mapped onto rsp_err.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CYCLE,
    RESP
  } wb_state_e;

  typedef enum logic [1:0] {
    RSP_OK,
    RSP_BUS_ERR,
    RSP_TIMEOUT
  } wb_rsp_e;

  function automatic logic rsp_is_err(input wb_rsp_e code);
    return code != RSP_OK;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - bus-cycle watchdog counter, built only with WB_TIMEOUT_EN
// Counts stalled CYCLE edges and flags expiry once TIMEOUT_CYC have elapsed.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at the limit so a held enable cannot wrap past expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - valid/ready request to Wishbone classic single-cycle master
// Optional watchdog abort of stalled cycles when WB_TIMEOUT_EN is defined.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = DATA_W / 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  wb_state_e         r_state;
  wb_state_e         w_next;
  wb_rsp_e           w_code;
  logic              w_done;
  logic              w_accept;
  logic              w_timeout;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_wdata;
  logic [SEL_W-1:0]  r_sel;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  assign req_ready = (r_state != CYCLE);
  assign w_accept  = req_valid && req_ready;

`ifdef WB_TIMEOUT_EN
  logic w_to_enable;

  assign w_to_enable = (r_state == CYCLE) && !wb_ack_i && !wb_err_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .enable (w_to_enable),
    .expired(w_timeout)
  );
`else
  logic w_unused_timeout_cyc;

  assign w_unused_timeout_cyc = (TIMEOUT_CYC > 0);
  assign w_timeout            = 1'b0;
`endif

  // Bus error outranks a simultaneous ack; the watchdog only fires on an otherwise silent edge.
  always_comb begin
    w_next = r_state;
    w_code = RSP_OK;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) w_next = CYCLE;
      end
      CYCLE: begin
        if (wb_err_i) begin
          w_code = RSP_BUS_ERR;
          w_done = 1'b1;
        end else if (wb_ack_i) begin
          w_code = RSP_OK;
          w_done = 1'b1;
        end else if (w_timeout) begin
          w_code = RSP_TIMEOUT;
          w_done = 1'b1;
        end
        if (w_done) w_next = RESP;
      end
      RESP: begin
        w_next = req_valid ? CYCLE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_adr   <= req_adr;
        r_wdata <= req_wdata;
        r_sel   <= req_sel;
        r_we    <= req_we;
      end
      if (w_done) begin
        r_rdata <= (w_code == RSP_OK && !r_we) ? wb_dat_i : '0;
        r_err   <= rsp_is_err(w_code);
      end
    end
  end

  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_wdata;
  assign wb_sel_o  = r_sel;
  assign wb_we_o   = r_we;
  assign wb_cyc_o  = (r_state == CYCLE);
  assign wb_stb_o  = (r_state == CYCLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Parametrised Wishbone classic master. Converts a CPU-side valid/ready request channel into single Wishbone read/write cycles, and returns one response per request.
Generalises the fixed 16-bit wishbone bundle to configurable address, data and select widths. Adds explicit request/response handshakes, bus-error reporting and an optional timeout watchdog.
Sits between the CPU load/store unit and the system Wishbone interconnect.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 16, data width in bits; must be a multiple of 8
SEL_W, DATA_W/8, byte-select width
TIMEOUT_CYC, 255, cycles with stb high and no ack before abort (used only with WB_TIMEOUT_EN); must be >= 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  bridge can accept a request
req_we  in  1  0 = read, 1 = write
req_adr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_sel  in  SEL_W  byte enables
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  response terminated by bus error or timeout
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_dat_i  in  DATA_W  Wishbone read data
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  SEL_W  Wishbone byte select
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error

Behaviour:
- Reset (reset = 0, async): state = IDLE; all outputs 0 except req_ready = 1; timeout counter = 0.
- FSM states: IDLE, CYCLE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch adr/wdata/sel/we into wb_* registers, go to CYCLE.
- CYCLE:
  - wb_cyc_o = wb_stb_o = 1; wb_* outputs held stable; req_ready = 0.
  - On a sampled edge with wb_ack_i or wb_err_i: cyc/stb drop, go to RESP.
  - Read with ack: rsp_rdata <= wb_dat_i.
  - Otherwise: rsp_rdata <= 0; rsp_err <= wb_err_i.
- RESP:
  - rsp_valid = 1 for exactly one cycle; rsp_rdata/rsp_err valid in that cycle.
  - req_ready = 1; a request accepted here goes directly to CYCLE (back-to-back, one idle bus cycle between cycles).
  - Otherwise go to IDLE.
- Latency:
  - Accept at edge N; stb high from N.
  - Zero-wait slave acks at edge N+1; rsp_valid high from N+1 for one cycle.
  - Each slave wait state adds one cycle.
- Simultaneous ack and err: err wins (rsp_err = 1, rdata = 0).
- ack/err while not in CYCLE: ignored.
- rsp_rdata and rsp_err hold their last value after rsp_valid falls; consumers sample only on rsp_valid.
- Reset mid-CYCLE: cyc/stb drop immediately; no response is issued; the request is lost.
- req_valid is not required to hold after acceptance; fields are registered at the accept edge.

Optional Feature:
Macro WB_TIMEOUT_EN.
- Defined:
  - Counter increments on each CYCLE edge without ack/err; cleared on entering CYCLE.
  - When the count reaches TIMEOUT_CYC (no ack/err on that edge): abort the cycle, go to RESP with rsp_err = 1, rsp_rdata = 0.
  - Counter width = $clog2(TIMEOUT_CYC+1).
  - Error cycle = TIMEOUT_CYC + 1 cycles after accept.
- Undefined: no counter logic; CYCLE waits indefinitely; TIMEOUT_CYC unused.

Decomposition:
- Package wb_pkg: state enum (IDLE, CYCLE, RESP); response-code typedef (OK, BUS_ERR, TIMEOUT), used internally before mapping to rsp_err.
- One sub-module: wb_timeout_cnt (clear, enable, expired), instantiated only under WB_TIMEOUT_EN.

Test Plan:
- Read 0x1234, slave returns 0xBEEF with zero wait -> stb high 1 cycle; rsp_valid 1 cycle after; rsp_rdata = 0xBEEF, rsp_err = 0.
- Write 0x0040 data 0xA5A5 sel 0b10, slave acks after 3 wait states -> wb_dat_o = 0xA5A5 and wb_sel_o = 0b10 stable 4 cycles; rsp_rdata = 0, rsp_err = 0.
- Back-to-back: second req_valid held during RESP -> accepted in RESP; next stb one cycle after rsp_valid; two responses in order.
- ack and err asserted together on a read -> rsp_err = 1, rsp_rdata = 0.
- WB_TIMEOUT_EN, TIMEOUT_CYC = 8, slave never acks -> cyc drops, rsp_valid with rsp_err = 1 at cycle 9 after accept; next request then accepted normally.
- reset pulsed low mid-CYCLE -> cyc/stb 0 asynchronously, no rsp_valid, req_ready = 1 after release; DATA_W = 32 build repeats the read test with 0xDEADBEEF.
